// File: rtl/boreal_safety_pkg.sv
// Shared types and helpers for the Boreal safety controller and watchdog.
// State encoding is fixed because the state port is observed externally.
package boreal_safety_pkg;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_RUN     = 3'd1,
        ST_HALTING = 3'd2,
        ST_HALTED  = 3'd3,
        ST_RECOVER = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

    localparam logic [7:0] FAULT_SAT = 8'hFF;

    // 64-bit math so large clocks times long windows cannot overflow
    function automatic longint unsigned ms_to_cycles(input longint unsigned clk_freq,
                                                     input longint unsigned ms);
        return (clk_freq / 64'd1000) * ms;
    endfunction

    // Timers hold (cycles - 1), so $clog2(cycles) bits suffice; never narrower than 1
    function automatic int unsigned timer_width(input longint unsigned cycles);
        return (cycles <= 64'd2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/boreal_ms_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Loading N-1 gives exactly N cycles in the owning state before expiry.
module boreal_ms_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/boreal_safety_ctrl.sv
// Safety controller consuming the watchdog stall line: halts stimulation on stall,
// waits for acknowledge and hold time, re-arms on proven heartbeat, locks out on repeat faults.
module boreal_safety_ctrl
    import boreal_safety_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned ACK_TIMEOUT_MS = 10,
    parameter int unsigned HOLD_MS        = 100,
    parameter int unsigned RECOVER_BEATS  = 4,
    parameter int unsigned MAX_FAULTS     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       heartbeat,
    input  logic       halt_ack,
    input  logic       operator_clear,
    output logic       halt_req,
    output logic       output_enable,
    output logic [2:0] state,
    output logic [7:0] fault_count,
    output logic       ack_fault,
    output logic       lockout
);

    localparam longint unsigned ACK_CYC  = ms_to_cycles(CLK_FREQ, ACK_TIMEOUT_MS);
    localparam longint unsigned HOLD_CYC = ms_to_cycles(CLK_FREQ, HOLD_MS);
    localparam int unsigned     ACK_W    = timer_width(ACK_CYC);
    localparam int unsigned     HOLD_W   = timer_width(HOLD_CYC);
    localparam logic [ACK_W-1:0]  ACK_LOAD  =
        ACK_W'((ACK_CYC == 64'd0) ? 64'd0 : ACK_CYC - 64'd1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        HOLD_W'((HOLD_CYC == 64'd0) ? 64'd0 : HOLD_CYC - 64'd1);
    localparam int unsigned      BEAT_W   = (RECOVER_BEATS < 1) ? 1 : $clog2(RECOVER_BEATS + 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_d;
    logic [7:0]        fault_cnt_d;
    logic              ack_fault_d;
    logic              ack_load, hold_load, ack_expired, hold_expired;
    logic              beat_last;

    assign beat_last = (32'(beat_cnt) + 32'd1) >= RECOVER_BEATS;
    // Timers reload on the edge that enters their state, including RECOVER -> HALTED
    assign ack_load  = (state_d == ST_HALTING) && (state_q != ST_HALTING);
    assign hold_load = (state_d == ST_HALTED)  && (state_q != ST_HALTED);

    boreal_ms_timer #(.WIDTH(ACK_W)) u_ack_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ack_load),
        .load_val (ACK_LOAD),
        .expired  (ack_expired)
    );

    boreal_ms_timer #(.WIDTH(HOLD_W)) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .expired  (hold_expired)
    );

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = '0;
        fault_cnt_d = fault_count;
        ack_fault_d = ack_fault;
        case (state_q)
            ST_BOOT, ST_RECOVER: begin
                beat_cnt_d = beat_cnt;
                // stall has priority: a coincident heartbeat is discarded
                if (stall) begin
                    beat_cnt_d = '0;
                    if (state_q == ST_RECOVER) begin
                        state_d = ST_HALTED;
                    end
                end else if (heartbeat) begin
                    if (beat_last) begin
                        beat_cnt_d = '0;
                        state_d    = ST_RUN;
                    end else begin
                        beat_cnt_d = beat_cnt + BEAT_ONE;
                    end
                end
            end
            ST_RUN: begin
                if (stall) begin
                    state_d = ST_HALTING;
                    if (fault_count != FAULT_SAT) begin
                        fault_cnt_d = fault_count + 8'd1;
                    end
                end
            end
            ST_HALTING: begin
                if (halt_ack) begin
                    state_d = ST_HALTED;
                end else if (ack_expired) begin
                    state_d     = ST_LOCKOUT;
                    ack_fault_d = 1'b1;
                end
            end
            ST_HALTED: begin
                if (hold_expired) begin
                    if (32'(fault_count) >= MAX_FAULTS) begin
                        state_d = ST_LOCKOUT;
                    end else if (!stall) begin
                        state_d = ST_RECOVER;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (operator_clear && !stall) begin
                    state_d     = ST_BOOT;
                    fault_cnt_d = 8'd0;
                    ack_fault_d = 1'b0;
                end
            end
            default: state_d = ST_LOCKOUT;
        endcase
    end

    // Outputs are decoded from the next state so they stay registered and consistent
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            beat_cnt      <= '0;
            fault_count   <= 8'd0;
            ack_fault     <= 1'b0;
            halt_req      <= 1'b1;
            output_enable <= 1'b0;
            lockout       <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt      <= beat_cnt_d;
            fault_count   <= fault_cnt_d;
            ack_fault     <= ack_fault_d;
            halt_req      <= (state_d != ST_RUN);
            output_enable <= (state_d == ST_RUN);
            lockout       <= (state_d == ST_LOCKOUT);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_boreal_safety_ctrl.sv
// Directed bench for boreal_safety_ctrl at 1 ms = 1 cycle; a second instance
// with an unreachable fault limit exercises fault_count saturation.
module tb_boreal_safety_ctrl;
    import boreal_safety_pkg::*;

    logic       clk = 1'b0;
    logic       rst, stall, heartbeat, halt_ack, operator_clear;
    logic       halt_req, output_enable, ack_fault, lockout;
    logic [2:0] state;
    logic [7:0] fault_count;

    logic       s2_stall, s2_hb, s2_ack, s2_clr;
    logic       s2_halt_req, s2_oe, s2_ack_fault, s2_lockout;
    logic [2:0] s2_state;
    logic [7:0] s2_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    boreal_safety_ctrl #(
        .CLK_FREQ(1000), .ACK_TIMEOUT_MS(5), .HOLD_MS(8), .RECOVER_BEATS(4), .MAX_FAULTS(3)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .heartbeat(heartbeat), .halt_ack(halt_ack),
        .operator_clear(operator_clear), .halt_req(halt_req), .output_enable(output_enable),
        .state(state), .fault_count(fault_count), .ack_fault(ack_fault), .lockout(lockout)
    );

    boreal_safety_ctrl #(
        .CLK_FREQ(1000), .ACK_TIMEOUT_MS(5), .HOLD_MS(8), .RECOVER_BEATS(4), .MAX_FAULTS(256)
    ) dut_sat (
        .clk(clk), .rst(rst), .stall(s2_stall), .heartbeat(s2_hb), .halt_ack(s2_ack),
        .operator_clear(s2_clr), .halt_req(s2_halt_req), .output_enable(s2_oe),
        .state(s2_state), .fault_count(s2_fault), .ack_fault(s2_ack_fault), .lockout(s2_lockout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Enable must never be granted outside RUN or while a halt is requested
    always @(negedge clk) begin
        checks++;
        assert (output_enable === ((state == 3'd1) && !halt_req)) else begin
            errors++;
            $error("FAIL invariant_oe: observed %0d expected %0d", output_enable,
                   (state == 3'd1) && !halt_req);
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; heartbeat = 1'b0; halt_ack = 1'b0; operator_clear = 1'b0;
        s2_stall = 1'b0; s2_hb = 1'b0; s2_ack = 1'b0; s2_clr = 1'b0;
        tick(2);
        chk("rst_state", state, 3'd0);
        chk("rst_halt_req", halt_req, 1);
        chk("rst_oe", output_enable, 0);
        chk("rst_fault", fault_count, 0);
        chk("rst_ack_fault", ack_fault, 0);
        chk("rst_lockout", lockout, 0);
        rst = 1'b0;

        // 1: four clean heartbeats from BOOT
        heartbeat = 1'b1;
        tick(3);
        chk("t1_boot_after3", state, 3'd0);
        tick(1);
        heartbeat = 1'b0;
        chk("t1_run", state, 3'd1);
        chk("t1_oe", output_enable, 1);
        chk("t1_halt_req", halt_req, 0);
        operator_clear = 1'b1;
        tick(1);
        operator_clear = 1'b0;
        chk("t1_clr_ignored", state, 3'd1);

        // 2: stall in RUN, ack two cycles later
        stall = 1'b1;
        tick(1);
        stall = 1'b0;
        chk("t2_halting", state, 3'd2);
        chk("t2_halt_req", halt_req, 1);
        chk("t2_oe", output_enable, 0);
        chk("t2_fault", fault_count, 1);
        tick(1);
        chk("t2_still_halting", state, 3'd2);
        halt_ack = 1'b1;
        tick(1);
        halt_ack = 1'b0;
        chk("t2_halted", state, 3'd3);

        // 3: hold, interrupted recovery, clean recovery
        tick(7);
        chk("t3_hold7", state, 3'd3);
        tick(1);
        chk("t3_recover", state, 3'd4);
        heartbeat = 1'b1;
        tick(2);
        heartbeat = 1'b0;
        stall = 1'b1;
        tick(1);
        stall = 1'b0;
        chk("t3_back_halted", state, 3'd3);
        chk("t3_fault_same", fault_count, 1);
        tick(8);
        chk("t3_recover2", state, 3'd4);
        heartbeat = 1'b1;
        tick(3);
        chk("t3_recover_3beats", state, 3'd4);
        tick(1);
        heartbeat = 1'b0;
        chk("t3_run", state, 3'd1);
        chk("t3_oe", output_enable, 1);

        // 4: ack timeout into LOCKOUT, operator clear gated by stall
        stall = 1'b1;
        tick(1);
        stall = 1'b0;
        chk("t4_fault2", fault_count, 2);
        tick(4);
        chk("t4_halting4", state, 3'd2);
        tick(1);
        chk("t4_lockout", state, 3'd5);
        chk("t4_ack_fault", ack_fault, 1);
        chk("t4_lockout_flag", lockout, 1);
        stall = 1'b1; operator_clear = 1'b1;
        tick(1);
        operator_clear = 1'b0;
        chk("t4_clear_stalled", state, 3'd5);
        stall = 1'b0; operator_clear = 1'b1;
        tick(1);
        operator_clear = 1'b0;
        chk("t4_boot", state, 3'd0);
        chk("t4_fault_clr", fault_count, 0);
        chk("t4_ack_fault_clr", ack_fault, 0);
        chk("t4_lockout_clr", lockout, 0);

        // 5: three faults force LOCKOUT; first one acks on the expiry cycle
        heartbeat = 1'b1; tick(4); heartbeat = 1'b0;
        stall = 1'b1; tick(1); stall = 1'b0;
        tick(4);
        halt_ack = 1'b1; tick(1); halt_ack = 1'b0;
        chk("t5_ack_wins", state, 3'd3);
        chk("t5_no_ack_fault", ack_fault, 0);
        tick(8);
        heartbeat = 1'b1; tick(4); heartbeat = 1'b0;
        stall = 1'b1; tick(1); stall = 1'b0;
        halt_ack = 1'b1; tick(1); halt_ack = 1'b0;
        tick(8);
        heartbeat = 1'b1; tick(4); heartbeat = 1'b0;
        chk("t5_run2", state, 3'd1);
        stall = 1'b1; tick(1); stall = 1'b0;
        chk("t5_fault3", fault_count, 3);
        halt_ack = 1'b1; tick(1); halt_ack = 1'b0;
        tick(7);
        chk("t5_hold", state, 3'd3);
        tick(1);
        chk("t5_lockout", state, 3'd5);
        chk("t5_lockout_flag", lockout, 1);
        operator_clear = 1'b1; tick(1); operator_clear = 1'b0;
        chk("t5_boot", state, 3'd0);

        // 6a: stall coincident with heartbeat in RECOVER
        heartbeat = 1'b1; tick(4); heartbeat = 1'b0;
        stall = 1'b1; tick(1); stall = 1'b0;
        halt_ack = 1'b1; tick(1); halt_ack = 1'b0;
        tick(8);
        heartbeat = 1'b1; tick(1);
        stall = 1'b1; tick(1);
        stall = 1'b0; heartbeat = 1'b0;
        chk("t6_halted", state, 3'd3);
        tick(8);
        heartbeat = 1'b1; tick(3);
        chk("t6_beats_cleared", state, 3'd4);
        tick(1);
        heartbeat = 1'b0;
        chk("t6_run", state, 3'd1);
        chk("t6_fault1", fault_count, 1);

        // 6b: reset while HALTING
        stall = 1'b1; tick(1); stall = 1'b0;
        tick(1);
        chk("t6_pre_rst", state, 3'd2);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("t6_rst_state", state, 3'd0);
        chk("t6_rst_halt_req", halt_req, 1);
        chk("t6_rst_oe", output_enable, 0);
        chk("t6_rst_fault", fault_count, 0);
        chk("t6_rst_ack_fault", ack_fault, 0);
        chk("t6_rst_lockout", lockout, 0);

        // saturation: repeated stall cycles on the unlimited instance
        s2_hb = 1'b1; tick(4); s2_hb = 1'b0;
        chk("sat_run", s2_state, 3'd1);
        for (int i = 0; i < 256; i++) begin
            s2_stall = 1'b1; tick(1); s2_stall = 1'b0;
            if (i == 254) chk("sat_255", s2_fault, 255);
            s2_ack = 1'b1; tick(1); s2_ack = 1'b0;
            tick(8);
            s2_hb = 1'b1; tick(4); s2_hb = 1'b0;
        end
        chk("sat_hold_255", s2_fault, 255);
        chk("sat_state", s2_state, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
